// File: rtl/multicycle_alu_if.sv
// Execute-stage ALU bus: operation request from the control unit, with the
// handshake and registered result returned by the ALU.
interface multicycle_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       ALUctrl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;

    modport master (
        output start, ALUctrl, SrcA, SrcB,
        input  busy, done, ALUResult, Zero
    );

    modport slave (
        input  start, ALUctrl, SrcA, SrcB,
        output busy, done, ALUResult, Zero
    );
endinterface

// File: rtl/multicycle_alu.sv
// Registered RV32I ALU with iterative MUL/MULHU/DIVU/REMU and a start/done handshake.
// Define SIGNED_MULDIV_EN to add signed DIV (1110) and REM (1111) around the unsigned divider.
module multicycle_alu #(
    parameter int WIDTH    = 32,
    parameter int SH_WIDTH = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            rst,
    multicycle_alu_if.slave bus
);
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SRL   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;
`ifdef SIGNED_MULDIV_EN
    localparam logic [3:0] OP_DIV   = 4'b1110;
    localparam logic [3:0] OP_REM   = 4'b1111;
`endif

    localparam logic [WIDTH-1:0]    ALL_ONES = {WIDTH{1'b1}};
    localparam logic [SH_WIDTH-1:0] LAST_CNT = SH_WIDTH'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              state_r;
    logic [3:0]          op_r;
    logic [SH_WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0]    hi_r;
    logic [WIDTH-1:0]    lo_r;
    logic [WIDTH-1:0]    opnd_r;
    logic [WIDTH-1:0]    result_r;
    logic                zero_r;
    logic                done_r;
    logic                busy_r;
`ifdef SIGNED_MULDIV_EN
    logic                neg_quo_r;
    logic                neg_rem_r;
    logic                neg_quo_s;
    logic                ovf_s;
    logic [WIDTH-1:0]    mag_a_s;
    logic [WIDTH-1:0]    mag_b_s;
`endif

    logic [SH_WIDTH-1:0] sh_s;
    logic [WIDTH-1:0]    quick_val_s;
    logic                launch_s;
    logic [WIDTH-1:0]    ld_lo_s;
    logic [WIDTH-1:0]    ld_opnd_s;

    logic                is_mul_s;
    logic [WIDTH:0]      mul_sum_s;
    logic [WIDTH:0]      div_part_s;
    logic                div_ge_s;
    logic [WIDTH-1:0]    div_diff_s;
    logic [WIDTH-1:0]    nxt_hi_s;
    logic [WIDTH-1:0]    nxt_lo_s;
    logic [WIDTH-1:0]    fin_s;

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.ALUResult = result_r;
    assign bus.Zero      = zero_r;

    // Decode a new request: single-cycle result, or operand preload for an iterative op.
    always_comb begin
        sh_s        = bus.SrcB[SH_WIDTH-1:0];
        quick_val_s = '0;
        launch_s    = 1'b0;
        ld_lo_s     = bus.SrcB;
        ld_opnd_s   = bus.SrcA;
`ifdef SIGNED_MULDIV_EN
        mag_a_s   = bus.SrcA[WIDTH-1] ? (~bus.SrcA + WIDTH'(1)) : bus.SrcA;
        mag_b_s   = bus.SrcB[WIDTH-1] ? (~bus.SrcB + WIDTH'(1)) : bus.SrcB;
        neg_quo_s = bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1];
        ovf_s     = (bus.SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.SrcB == ALL_ONES);
`endif
        case (bus.ALUctrl)
            OP_ADD:  quick_val_s = bus.SrcA + bus.SrcB;
            OP_SUB:  quick_val_s = bus.SrcA - bus.SrcB;
            OP_AND:  quick_val_s = bus.SrcA & bus.SrcB;
            OP_OR:   quick_val_s = bus.SrcA | bus.SrcB;
            OP_XOR:  quick_val_s = bus.SrcA ^ bus.SrcB;
            OP_SLL:  quick_val_s = bus.SrcA << sh_s;
            OP_SRL:  quick_val_s = bus.SrcA >> sh_s;
            OP_SRA:  quick_val_s = WIDTH'($signed(bus.SrcA) >>> sh_s);
            OP_SLT:  quick_val_s = WIDTH'($signed(bus.SrcA) < $signed(bus.SrcB));
            OP_SLTU: quick_val_s = WIDTH'(bus.SrcA < bus.SrcB);
            OP_MUL, OP_MULHU: begin
                launch_s = 1'b1;
            end
            OP_DIVU, OP_REMU: begin
                ld_lo_s   = bus.SrcA;
                ld_opnd_s = bus.SrcB;
                if (bus.SrcB == '0) begin
                    quick_val_s = (bus.ALUctrl == OP_DIVU) ? ALL_ONES : bus.SrcA;
                end else begin
                    launch_s = 1'b1;
                end
            end
`ifdef SIGNED_MULDIV_EN
            // Divide by zero and the single overflow case bypass the iteration.
            OP_DIV, OP_REM: begin
                ld_lo_s   = mag_a_s;
                ld_opnd_s = mag_b_s;
                if (bus.SrcB == '0) begin
                    quick_val_s = (bus.ALUctrl == OP_DIV) ? ALL_ONES : bus.SrcA;
                end else if (ovf_s) begin
                    quick_val_s = (bus.ALUctrl == OP_DIV) ? bus.SrcA : '0;
                end else begin
                    launch_s = 1'b1;
                end
            end
`endif
            default: quick_val_s = '0;
        endcase
    end

    // One shift-add multiply step or one restoring shift-subtract divide step.
    always_comb begin
        is_mul_s   = (op_r == OP_MUL) || (op_r == OP_MULHU);
        mul_sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        div_part_s = {hi_r, lo_r[WIDTH-1]};
        div_ge_s   = (div_part_s >= {1'b0, opnd_r});
        div_diff_s = div_part_s[WIDTH-1:0] - opnd_r;
        if (is_mul_s) begin
            nxt_hi_s = mul_sum_s[WIDTH:1];
            nxt_lo_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
        end else if (div_ge_s) begin
            nxt_hi_s = div_diff_s;
            nxt_lo_s = {lo_r[WIDTH-2:0], 1'b1};
        end else begin
            nxt_hi_s = div_part_s[WIDTH-1:0];
            nxt_lo_s = {lo_r[WIDTH-2:0], 1'b0};
        end
        case (op_r)
            OP_MUL, OP_DIVU:   fin_s = nxt_lo_s;
            OP_MULHU, OP_REMU: fin_s = nxt_hi_s;
`ifdef SIGNED_MULDIV_EN
            OP_DIV:  fin_s = neg_quo_r ? (~nxt_lo_s + WIDTH'(1)) : nxt_lo_s;
            OP_REM:  fin_s = neg_rem_r ? (~nxt_hi_s + WIDTH'(1)) : nxt_hi_s;
`endif
            default: fin_s = '0;
        endcase
    end

    // Control FSM with registered handshake and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            op_r      <= 4'b0000;
            cnt_r     <= '0;
            hi_r      <= '0;
            lo_r      <= '0;
            opnd_r    <= '0;
            result_r  <= '0;
            zero_r    <= 1'b1;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
`ifdef SIGNED_MULDIV_EN
            neg_quo_r <= 1'b0;
            neg_rem_r <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (launch_s) begin
                            state_r   <= ST_BUSY;
                            busy_r    <= 1'b1;
                            op_r      <= bus.ALUctrl;
                            cnt_r     <= '0;
                            hi_r      <= '0;
                            lo_r      <= ld_lo_s;
                            opnd_r    <= ld_opnd_s;
`ifdef SIGNED_MULDIV_EN
                            neg_quo_r <= neg_quo_s;
                            neg_rem_r <= bus.SrcA[WIDTH-1];
`endif
                        end else begin
                            result_r <= quick_val_s;
                            zero_r   <= (quick_val_s == '0);
                            done_r   <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    hi_r  <= nxt_hi_s;
                    lo_r  <= nxt_lo_s;
                    cnt_r <= cnt_r + SH_WIDTH'(1);
                    if (cnt_r == LAST_CNT) begin
                        state_r  <= ST_IDLE;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        result_r <= fin_s;
                        zero_r   <= (fin_s == '0);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_alu.sv
// Directed table-driven bench for multicycle_alu, plus hand sequences for reset and handshake corners.
module tb_multicycle_alu;
    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_SLL   = 4'h5;
    localparam logic [3:0] OP_SRL   = 4'h6;
    localparam logic [3:0] OP_SRA   = 4'h7;
    localparam logic [3:0] OP_SLT   = 4'h8;
    localparam logic [3:0] OP_SLTU  = 4'h9;
    localparam logic [3:0] OP_MUL   = 4'hA;
    localparam logic [3:0] OP_MULHU = 4'hB;
    localparam logic [3:0] OP_DIVU  = 4'hC;
    localparam logic [3:0] OP_REMU  = 4'hD;
    localparam logic [3:0] OP_DIV   = 4'hE;
    localparam logic [3:0] OP_REM   = 4'hF;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs[$];

    multicycle_alu_if #(.WIDTH(32)) bus ();

    multicycle_alu #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp, input int lat, input string nm);
        vec_t v;
        v.ctrl = c; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.name = nm;
        vecs.push_back(v);
    endfunction

    // Issue one op and follow it to done, checking latency, busy profile, result and Zero.
    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string nm);
        int cyc;
        bit busy_ok;
        bus.start   = 1'b1;
        bus.ALUctrl = c;
        bus.SrcA    = a;
        bus.SrcB    = b;
        step();
        bus.start = 1'b0;
        cyc     = 1;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && cyc < 100) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            step();
            cyc++;
        end
        chk({nm, " latency"}, 32'(cyc), 32'(lat));
        chk({nm, " result"}, bus.ALUResult, exp);
        chk({nm, " zero"}, {31'd0, bus.Zero}, {31'd0, exp == 32'd0});
        chk({nm, " busy"}, {30'd0, busy_ok, bus.busy}, 32'd2);
    endtask

    initial begin
        int cyc;
        int done_seen;

        bus.start   = 1'b0;
        bus.ALUctrl = 4'h0;
        bus.SrcA    = 32'd0;
        bus.SrcB    = 32'd0;
        rst = 1'b1;
        step();
        step();
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset result", bus.ALUResult, 32'd0);
        chk("reset zero", {31'd0, bus.Zero}, 32'd1);
        rst = 1'b0;
        step();

        add(OP_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1,  "add wrap");
        add(OP_SUB,   32'd5,        32'd3,        32'd2,        1,  "sub");
        add(OP_AND,   32'hF0F000FF, 32'h0FF0F0F0, 32'h00F000F0, 1,  "and");
        add(OP_OR,    32'h00000F00, 32'h000000F0, 32'h00000FF0, 1,  "or");
        add(OP_XOR,   32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1,  "xor");
        add(OP_SLL,   32'h00000001, 32'h00000021, 32'h00000002, 1,  "sll masked");
        add(OP_SRL,   32'h80000000, 32'd31,       32'h00000001, 1,  "srl");
        add(OP_SRA,   32'h80000000, 32'h00000024, 32'hF8000000, 1,  "sra");
        add(OP_SLT,   32'hFFFFFFFF, 32'd1,        32'd1,        1,  "slt");
        add(OP_SLTU,  32'hFFFFFFFF, 32'd1,        32'd0,        1,  "sltu");
        add(OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33, "mul max");
        add(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu max");
        add(OP_MUL,   32'd7,        32'd6,        32'd42,       33, "mul 7x6");
        add(OP_MULHU, 32'h00010000, 32'h00010000, 32'h00000001, 33, "mulhu 2^32");
        add(OP_DIVU,  32'd100,      32'd7,        32'd14,       33, "divu");
        add(OP_REMU,  32'd100,      32'd7,        32'd2,        33, "remu");
        add(OP_DIVU,  32'd100,      32'd0,        32'hFFFFFFFF, 1,  "divu by 0");
        add(OP_REMU,  32'd100,      32'd0,        32'd100,      1,  "remu by 0");
        add(OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33, "divu by 1");
        add(OP_REMU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 33, "remu by 16");
`ifdef SIGNED_MULDIV_EN
        add(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div -7/2");
        add(OP_REM,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem -7/2");
        add(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, "div 7/-2");
        add(OP_REM,   32'd7,        32'hFFFFFFFE, 32'd1,        33, "rem 7/-2");
        add(OP_DIV,   32'h80000000, 32'd2,        32'hC0000000, 33, "div minneg/2");
        add(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div overflow");
        add(OP_REM,   32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  "rem overflow");
        add(OP_DIV,   32'd5,        32'd0,        32'hFFFFFFFF, 1,  "div by 0");
        add(OP_REM,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1,  "rem by 0");
`else
        add(OP_DIV,   32'd9,        32'd3,        32'd0,        1,  "code 1110 unsupported");
        add(OP_REM,   32'd9,        32'd4,        32'd0,        1,  "code 1111 unsupported");
`endif

        foreach (vecs[i]) begin
            run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);
            step();
            chk({vecs[i].name, " done drop"}, {31'd0, bus.done}, 32'd0);
            chk({vecs[i].name, " hold"}, bus.ALUResult, vecs[i].exp);
        end

        // Reset in cycle 10 of a multiply: aborts, clears result, no done afterwards.
        run_op(OP_SUB, 32'd5, 32'd3, 32'd2, 1, "pre-reset sub");
        bus.start = 1'b1; bus.ALUctrl = OP_MUL; bus.SrcA = 32'd7; bus.SrcB = 32'd6;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        chk("mid-mul busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort busy", {31'd0, bus.busy}, 32'd0);
        chk("abort done", {31'd0, bus.done}, 32'd0);
        chk("abort result", bus.ALUResult, 32'd0);
        chk("abort zero", {31'd0, bus.Zero}, 32'd1);
        done_seen = 0;
        repeat (40) begin
            step();
            if (bus.done === 1'b1) done_seen++;
        end
        chk("abort no done", 32'(done_seen), 32'd0);

        // start during BUSY is ignored, then a start in the done cycle is accepted.
        bus.start = 1'b1; bus.ALUctrl = OP_DIVU; bus.SrcA = 32'd100; bus.SrcB = 32'd7;
        step();
        bus.start = 1'b0;
        cyc = 1;
        repeat (3) begin step(); cyc++; end
        bus.start = 1'b1; bus.ALUctrl = OP_ADD; bus.SrcA = 32'd1; bus.SrcB = 32'd2;
        step();
        cyc++;
        bus.start = 1'b0;
        chk("ignored start done", {31'd0, bus.done}, 32'd0);
        while (bus.done !== 1'b1 && cyc < 100) begin step(); cyc++; end
        chk("divu under start latency", 32'(cyc), 32'd33);
        chk("divu under start result", bus.ALUResult, 32'd14);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start in done cycle done", {31'd0, bus.done}, 32'd1);
        chk("start in done cycle result", bus.ALUResult, 32'd3);
        step();

        // Back-to-back single-cycle ops with start held high.
        bus.start = 1'b1; bus.ALUctrl = OP_ADD; bus.SrcA = 32'd10; bus.SrcB = 32'd20;
        step();
        chk("b2b add done", {31'd0, bus.done}, 32'd1);
        chk("b2b add result", bus.ALUResult, 32'd30);
        bus.ALUctrl = OP_SUB; bus.SrcA = 32'd7; bus.SrcB = 32'd7;
        step();
        chk("b2b sub done", {31'd0, bus.done}, 32'd1);
        chk("b2b sub zero", {31'd0, bus.Zero}, 32'd1);
        bus.ALUctrl = OP_OR; bus.SrcA = 32'h0000A000; bus.SrcB = 32'h00000005;
        step();
        bus.start = 1'b0;
        chk("b2b or done", {31'd0, bus.done}, 32'd1);
        chk("b2b or result", bus.ALUResult, 32'h0000A005);
        step();
        chk("b2b idle done", {31'd0, bus.done}, 32'd0);
        chk("b2b idle hold", bus.ALUResult, 32'h0000A005);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Parametrised successor to the single-cycle datapath ALU.
- Registered ALU covering the full RV32I integer op set plus iterative multiply and unsigned divide/remainder (M-extension subset), with a start/done handshake.
- Sits in the execute stage; the control unit stalls the PC while busy is high.
- Zero is derived from the registered result, so SUB supports beq/bne.

Parameters:
- WIDTH, 32, operand and result width in bits (power of two, >= 8).
- SH_WIDTH, $clog2(WIDTH), number of SrcB LSBs used as shift amount.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only when busy=0.
- ALUctrl  input  4  operation select, sampled with start.
- SrcA  input  WIDTH  operand A, sampled with start.
- SrcB  input  WIDTH  operand B, sampled with start.
- busy  output  1  iterative op in progress.
- done  output  1  one-cycle pulse; ALUResult/Zero valid and updated this cycle.
- ALUResult  output  WIDTH  registered result, held until the next done.
- Zero  output  1  registered (ALUResult == 0), updated with ALUResult.

Behaviour:
- Reset: on a clk edge with rst=1 → state IDLE, busy=0, done=0, ALUResult=0, Zero=1, counter and internal accumulators cleared. rst overrides start and aborts any in-flight op; no done pulse follows.
- ALUctrl encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount is SrcB[SH_WIDTH-1:0].
  - 1000 SLT (signed), 1001 SLTU; result is 0 or 1, zero-extended.
  - 1010 MUL (low WIDTH bits of product), 1011 MULHU (high WIDTH bits, unsigned).
  - 1100 DIVU, 1101 REMU.
  - 1110/1111 reserved, see Optional Feature.
- Arithmetic wraps modulo 2^WIDTH; no overflow flag.
- FSM states: IDLE, BUSY.
  - IDLE with start=1 and a single-cycle op (0000–1001, or unsupported code) → result registered at that edge; done=1 for the next cycle; remain IDLE. Latency 1.
  - IDLE with start=1 and MUL/MULHU/DIVU/REMU → operands latched, counter=0, go to BUSY; busy=1 from the next cycle.
  - BUSY: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, counter increments. After WIDTH steps → IDLE, busy=0, done=1 in the same cycle the result appears.
  - Iterative latency is WIDTH+1 cycles from the start edge: busy is high in cycles 1..WIDTH, done in cycle WIDTH+1.
- Divide by zero (DIVU/REMU with SrcB=0): no iteration. Latency 1; DIVU → all ones, REMU → SrcA.
- Unsupported code: ALUResult=0, Zero=1, done at latency 1.
- start while busy=1: ignored; operands are not resampled.
- start in the same cycle done=1: accepted (IDLE); back-to-back single-cycle ops give a done pulse every cycle.
- ALUResult/Zero change only on done (or reset); they hold between operations.

Optional Feature:
- Macro: SIGNED_MULDIV_EN.
- Defined:
  - 1110 DIV (signed, truncate toward zero) and 1111 REM (signed, sign follows dividend), via sign-magnitude around the unsigned divider. Latency WIDTH+1.
  - Divide by zero: DIV → all ones (-1), REM → SrcA. Both at latency 1.
  - Overflow (SrcA = most-negative, SrcB = -1): DIV → most-negative, REM → 0. Both at latency 1.
- Undefined: 1110/1111 are treated as unsupported codes (result 0, latency 1); no signed-correction logic is synthesised.

Test Plan:
- Reset mid-MUL: start MUL 7×6, assert rst in cycle 10 → busy=0 the next cycle, no done pulse, ALUResult=0, Zero=1.
- Single-cycle ops: ADD 0xFFFFFFFF+1 → done cycle 1, ALUResult=0, Zero=1. SUB 5-3 → 2, Zero=0. SRA 0x80000000 by SrcB=0x24 (shift 4) → 0xF8000000. SLT -1<1 → 1. SLTU 0xFFFFFFFF<1 → 0.
- MUL and MULHU: 0xFFFFFFFF × 0xFFFFFFFF → MUL=0x00000001, MULHU=0xFFFFFFFE. Each shows busy high cycles 1–32 and done exactly in cycle 33.
- DIVU/REMU: 100/7 → 14 and 2 at cycle 33. 100/0 → DIVU=0xFFFFFFFF, REMU=100 at cycle 1 with busy never asserted.
- Handshake: start ADD during BUSY of DIVU → ignored, DIVU result unaffected. start ADD 1+2 in the done cycle → done again the next cycle with ALUResult=3.
- SIGNED_MULDIV_EN defined:
  - DIV -7/2 → -3; REM -7/2 → -1.
  - DIV 0x80000000/-1 → 0x80000000; REM → 0.
  - Macro undefined: code 1110 → ALUResult=0, done at cycle 1.
